// File: rtl/trace_debugger_pkg.sv
// Shared trace encoding definitions: format codes, RISC-V opcode constants,
// packet field offsets/lengths and the assembled packet struct.
package trace_debugger_pkg;

  localparam int PKT_MAX_W = 113;
  localparam int MAP_W     = 31;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    FMT_F0 = 2'b00,
    FMT_F1 = 2'b01,
    FMT_F2 = 2'b10,
    FMT_F3 = 2'b11
  } fmt_e;

  typedef enum logic [1:0] {
    F3_SYNC = 2'b00,
    F3_EXC  = 2'b01
  } f3_sub_e;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [1:0] C_OP1     = 2'b01;
  localparam logic [1:0] C_OP2     = 2'b10;
  localparam logic [2:0] C_F3_BEQZ = 3'b110;
  localparam logic [2:0] C_F3_BNEZ = 3'b111;
  localparam logic [3:0] C_F4_JR   = 4'b1000;
  localparam logic [3:0] C_F4_JALR = 4'b1001;

  localparam int SYNC_PRIV = 4;
  localparam int SYNC_ADDR = 7;
  localparam int EXC_PRIV  = 4;
  localparam int EXC_CAUSE = 7;
  localparam int EXC_INTR  = 12;
  localparam int EXC_CNT   = 13;
  localparam int EXC_MAP   = 18;
  localparam int EXC_ADDR  = 49;
  localparam int EXC_TVAL  = 81;
  localparam int F1_CNT    = 2;
  localparam int F1_MAP    = 7;
  localparam int F1_ADDR   = 38;
  localparam int F2_ADDR   = 2;

  localparam logic [6:0] LEN_SYNC = 7'd39;
  localparam logic [6:0] LEN_EXC  = 7'd113;
  localparam logic [6:0] LEN_F1A  = 7'd70;
  localparam logic [6:0] LEN_F1   = 7'd38;
  localparam logic [6:0] LEN_F2   = 7'd34;

  typedef struct packed {
    logic [6:0]           len;
    logic [PKT_MAX_W-1:0] dat;
  } pkt_t;

  function automatic logic is_cond_branch(input logic [31:0] instr, input logic comp);
    if (comp)
      return (instr[1:0] == C_OP1) &&
             ((instr[15:13] == C_F3_BEQZ) || (instr[15:13] == C_F3_BNEZ));
    return instr[6:0] == OP_BRANCH;
  endfunction

  // c.jr/c.jalr need rs1!=0 and rs2==0; other encodings in that space are c.mv/c.add/c.ebreak
  function automatic logic is_uninf_jump(input logic [31:0] instr, input logic comp);
    if (comp)
      return (instr[1:0] == C_OP2) &&
             ((instr[15:12] == C_F4_JR) || (instr[15:12] == C_F4_JALR)) &&
             (instr[11:7] != 5'd0) && (instr[6:2] == 5'd0);
    return instr[6:0] == OP_JALR;
  endfunction

endpackage

// File: rtl/trace_debugger_if.sv
// Retirement port plus packet valid/ready output of the trace encoder.
// master = core/sink side, slave = encoder side.
interface trace_debugger_if #(parameter int PKT_W = 128);
  logic             ivalid_i;
  logic             iexception_i;
  logic             interrupt_i;
  logic [4:0]       cause_i;
  logic [31:0]      tval_i;
  logic [2:0]       priv_i;
  logic [31:0]      iaddr_i;
  logic [31:0]      instr_i;
  logic             compressed_i;
  logic             packet_valid_o;
  logic             packet_ready_i;
  logic [PKT_W-1:0] packet_o;
  logic [6:0]       packet_len_o;

  modport master (
    output ivalid_i, iexception_i, interrupt_i, cause_i, tval_i, priv_i,
           iaddr_i, instr_i, compressed_i, packet_ready_i,
    input  packet_valid_o, packet_o, packet_len_o
  );

  modport slave (
    input  ivalid_i, iexception_i, interrupt_i, cause_i, tval_i, priv_i,
           iaddr_i, instr_i, compressed_i, packet_ready_i,
    output packet_valid_o, packet_o, packet_len_o
  );
endinterface

// File: rtl/trdb_branch_map.sv
// Branch outcome shift register and count; cur_* are this cycle's post-resolution values.
// Zero latency to cur_*, state updates next edge; flush/clr empty the map.
module trdb_branch_map
  import trace_debugger_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             res_vld,
  input  logic             res_bit,
  input  logic             flush,
  output logic [MAP_W-1:0] cur_map,
  output logic [CNT_W-1:0] cur_cnt,
  output logic             full
);

  logic [MAP_W-1:0] map_q;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    cur_map = map_q;
    cur_cnt = cnt_q;
    if (res_vld && (cnt_q != CNT_W'(MAP_W))) begin
      cur_map[cnt_q] = res_bit;
      cur_cnt        = cnt_q + CNT_W'(1);
    end
  end

  assign full = (cur_cnt == CNT_W'(MAP_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      map_q <= '0;
      cnt_q <= '0;
    end else if (clr || flush) begin
      map_q <= '0;
      cnt_q <= '0;
    end else begin
      map_q <= cur_map;
      cnt_q <= cur_cnt;
    end
  end

endmodule

// File: rtl/trace_debugger.sv
// Instruction-trace encoder: classifies retirements, builds sync/branch/address/exception packets, 1-cycle latency.
// Single output register; a packet arriving while it is held without ready is dropped and overflow_o sticks.
module trace_debugger
  import trace_debugger_pkg::*;
#(
  parameter int PKT_W = 128  // must be >= PKT_MAX_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   test_mode_i,
  input  logic                   trace_enable_i,
  output logic                   overflow_o,
  trace_debugger_if.slave        tr
);

  logic             ev, exc, is_br, is_jmp;
  logic             sync_pend, pend_br, pend_comp, disc;
  logic [31:0]      pend_addr, fall_thru;
  logic             res_vld, res_bit, map_full;
  logic [MAP_W-1:0] cur_map;
  logic [CNT_W-1:0] cur_cnt;
  pkt_t             new_pkt, out_pkt;
  logic             new_vld, out_vld, overflow_q;
  logic             unused_bits;

  assign unused_bits = ^{test_mode_i, tr.instr_i[31:16]};

  assign ev     = tr.ivalid_i & trace_enable_i;
  assign exc    = tr.iexception_i;
  assign is_br  = is_cond_branch(tr.instr_i, tr.compressed_i);
  assign is_jmp = is_uninf_jump(tr.instr_i, tr.compressed_i);

  // Branch is not taken (map bit 1) when this retirement is its fall-through address
  assign fall_thru = pend_addr + (pend_comp ? 32'd2 : 32'd4);
  assign res_vld   = ev & pend_br;
  assign res_bit   = (tr.iaddr_i == fall_thru);

  trdb_branch_map u_map (
    .clk     (clk_i),
    .rst     (rst_i),
    .clr     (~trace_enable_i),
    .res_vld (res_vld),
    .res_bit (res_bit),
    .flush   (new_vld),
    .cur_map (cur_map),
    .cur_cnt (cur_cnt),
    .full    (map_full)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_pend <= 1'b1;
      pend_br   <= 1'b0;
      pend_addr <= '0;
      pend_comp <= 1'b0;
      disc      <= 1'b0;
    end else if (!trace_enable_i) begin
      sync_pend <= 1'b1;
      pend_br   <= 1'b0;
      disc      <= 1'b0;
    end else if (ev) begin
      sync_pend <= 1'b0;
      pend_br   <= is_br & ~exc;
      pend_addr <= tr.iaddr_i;
      pend_comp <= tr.compressed_i;
      disc      <= is_jmp | exc;
    end
  end

  always_comb begin
    new_pkt = '0;
    new_vld = 1'b0;
    if (ev) begin
      new_vld = 1'b1;
      if (sync_pend) begin
        new_pkt.dat[1:0]              = FMT_F3;
        new_pkt.dat[3:2]              = F3_SYNC;
        new_pkt.dat[SYNC_PRIV +: 3]   = tr.priv_i;
        new_pkt.dat[SYNC_ADDR +: 32]  = tr.iaddr_i;
        new_pkt.len                   = LEN_SYNC;
      end else if (exc) begin
        new_pkt.dat[1:0]              = FMT_F3;
        new_pkt.dat[3:2]              = F3_EXC;
        new_pkt.dat[EXC_PRIV +: 3]    = tr.priv_i;
        new_pkt.dat[EXC_CAUSE +: 5]   = tr.cause_i;
        new_pkt.dat[EXC_INTR]         = tr.interrupt_i;
        new_pkt.dat[EXC_CNT +: CNT_W] = cur_cnt;
        new_pkt.dat[EXC_MAP +: MAP_W] = cur_map;
        new_pkt.dat[EXC_ADDR +: 32]   = tr.iaddr_i;
        new_pkt.dat[EXC_TVAL +: 32]   = tr.tval_i;
        new_pkt.len                   = LEN_EXC;
      end else if (disc) begin
        if (cur_cnt != '0) begin
          new_pkt.dat[1:0]             = FMT_F1;
          new_pkt.dat[F1_CNT +: CNT_W] = cur_cnt;
          new_pkt.dat[F1_MAP +: MAP_W] = cur_map;
          new_pkt.dat[F1_ADDR +: 32]   = tr.iaddr_i;
          new_pkt.len                  = LEN_F1A;
        end else begin
          new_pkt.dat[1:0]            = FMT_F2;
          new_pkt.dat[F2_ADDR +: 32]  = tr.iaddr_i;
          new_pkt.len                 = LEN_F2;
        end
      end else if (map_full) begin
        new_pkt.dat[1:0]             = FMT_F1;
        new_pkt.dat[F1_MAP +: MAP_W] = cur_map;
        new_pkt.len                  = LEN_F1;
      end else begin
        new_vld = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_vld    <= 1'b0;
      out_pkt    <= '0;
      overflow_q <= 1'b0;
    end else if (new_vld && (!out_vld || tr.packet_ready_i)) begin
      out_vld <= 1'b1;
      out_pkt <= new_pkt;
    end else begin
      if (out_vld && tr.packet_ready_i)
        out_vld <= 1'b0;
      if (new_vld)
        overflow_q <= 1'b1;
    end
  end

  assign tr.packet_valid_o = out_vld;
  assign tr.packet_o       = PKT_W'(out_pkt.dat);
  assign tr.packet_len_o   = out_pkt.len;
  assign overflow_o        = overflow_q;

endmodule

// File: tb/tb_trace_debugger.sv
// Directed bench for trace_debugger: expected packets are queued as stimulus is driven
// and compared when the sink accepts them.
module tb_trace_debugger;

  logic clk = 1'b0;
  logic rst, test_mode, trace_enable, overflow;

  trace_debugger_if #(.PKT_W(128)) tr();

  trace_debugger #(.PKT_W(128)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .test_mode_i    (test_mode),
    .trace_enable_i (trace_enable),
    .overflow_o     (overflow),
    .tr             (tr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] dat;
    logic [6:0]   len;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] BEQ    = 32'h0000_0063;
  localparam logic [31:0] JALR   = 32'h0000_8067;
  localparam logic [31:0] C_NOP  = 32'h0000_0001;
  localparam logic [31:0] C_BEQZ = 32'h0000_C001;
  localparam logic [31:0] C_JR   = 32'h0000_8082;

  function automatic exp_t f3_sync(input logic [2:0] priv, input logic [31:0] a);
    exp_t e;
    e.dat = 128'h3 | (128'(priv) << 4) | (128'(a) << 7);
    e.len = 7'd39;
    return e;
  endfunction

  function automatic exp_t f3_exc(input logic [2:0] priv, input logic [4:0] cause,
                                  input logic intr, input logic [4:0] cnt,
                                  input logic [30:0] map, input logic [31:0] a,
                                  input logic [31:0] tval);
    exp_t e;
    e.dat = 128'h3 | (128'h1 << 2) | (128'(priv) << 4) | (128'(cause) << 7) |
            (128'(intr) << 12) | (128'(cnt) << 13) | (128'(map) << 18) |
            (128'(a) << 49) | (128'(tval) << 81);
    e.len = 7'd113;
    return e;
  endfunction

  function automatic exp_t f1a(input logic [4:0] cnt, input logic [30:0] map, input logic [31:0] a);
    exp_t e;
    e.dat = 128'h1 | (128'(cnt) << 2) | (128'(map) << 7) | (128'(a) << 38);
    e.len = 7'd70;
    return e;
  endfunction

  function automatic exp_t f1(input logic [30:0] map);
    exp_t e;
    e.dat = 128'h1 | (128'(map) << 7);
    e.len = 7'd38;
    return e;
  endfunction

  function automatic exp_t f2(input logic [31:0] a);
    exp_t e;
    e.dat = 128'h2 | (128'(a) << 2);
    e.len = 7'd34;
    return e;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic retire(input logic [31:0] a, input logic [31:0] ins, input logic comp,
                        input logic [2:0] priv);
    @(negedge clk);
    tr.ivalid_i     = 1'b1;
    tr.iexception_i = 1'b0;
    tr.iaddr_i      = a;
    tr.instr_i      = ins;
    tr.compressed_i = comp;
    tr.priv_i       = priv;
  endtask

  task automatic trap(input logic [31:0] a, input logic [2:0] priv, input logic [4:0] cause,
                      input logic intr, input logic [31:0] tval);
    retire(a, NOP, 1'b0, priv);
    tr.iexception_i = 1'b1;
    tr.cause_i      = cause;
    tr.interrupt_i  = intr;
    tr.tval_i       = tval;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tr.ivalid_i     = 1'b0;
      tr.iexception_i = 1'b0;
      tr.interrupt_i  = 1'b0;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    #2;
    check(tag, 128'(sb.size()), 128'd0);
  endtask

  // Sink: an accepted packet is the one at the head of the scoreboard
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (rst === 1'b0 && tr.packet_valid_o === 1'b1 && tr.packet_ready_i === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pkt observed=%h expected=none", tr.packet_o);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pkt_dat", tr.packet_o, e.dat);
        check("pkt_len", 128'(tr.packet_len_o), 128'(e.len));
      end
    end
  end

  initial begin
    rst = 1'b1; test_mode = 1'b0; trace_enable = 1'b0;
    tr.ivalid_i = 1'b0; tr.iexception_i = 1'b0; tr.interrupt_i = 1'b0;
    tr.cause_i = '0; tr.tval_i = '0; tr.priv_i = '0; tr.iaddr_i = '0;
    tr.instr_i = '0; tr.compressed_i = 1'b0; tr.packet_ready_i = 1'b0;

    repeat (3) sample();
    check("rst_valid", 128'(tr.packet_valid_o), 128'd0);
    check("rst_packet", tr.packet_o, 128'd0);
    check("rst_len", 128'(tr.packet_len_o), 128'd0);
    check("rst_overflow", 128'(overflow), 128'd0);

    @(negedge clk);
    rst = 1'b0; trace_enable = 1'b1; tr.packet_ready_i = 1'b1;

    // Sync on first event
    sb.push_back(f3_sync(3'd3, 32'h80));
    retire(32'h80, NOP, 1'b0, 3'd3);
    idle(2);
    drain("drain_sync");

    // Not-taken beq, then jalr discontinuity with one branch
    retire(32'h100, BEQ, 1'b0, 3'd3);
    retire(32'h104, NOP, 1'b0, 3'd3);
    retire(32'h108, JALR, 1'b0, 3'd3);
    sb.push_back(f1a(5'd1, 31'h1, 32'h200));
    retire(32'h200, NOP, 1'b0, 3'd3);
    idle(2);
    drain("drain_f1a");

    // 31 taken branches fill the map
    for (int k = 0; k < 31; k++) retire(32'h2000 + 32'(k) * 32'h40, BEQ, 1'b0, 3'd3);
    sb.push_back(f1(31'h0));
    retire(32'h2000 + 32'd31 * 32'h40, NOP, 1'b0, 3'd3);
    idle(2);
    drain("drain_full");

    // Exception with empty map, then F2
    sb.push_back(f3_exc(3'd3, 5'd2, 1'b0, 5'd0, 31'h0, 32'h300, 32'hdead));
    trap(32'h300, 3'd3, 5'd2, 1'b0, 32'hdead);
    sb.push_back(f2(32'h1000));
    retire(32'h1000, NOP, 1'b0, 3'd3);
    idle(2);
    drain("drain_exc");

    // Compressed branch and c.jr
    retire(32'h400, C_BEQZ, 1'b1, 3'd3);
    retire(32'h402, C_NOP, 1'b1, 3'd3);
    retire(32'h404, C_JR, 1'b1, 3'd3);
    sb.push_back(f1a(5'd1, 31'h1, 32'h500));
    retire(32'h500, NOP, 1'b0, 3'd3);
    idle(2);
    drain("drain_comp");

    // Interrupt resolving a taken branch on the same event
    retire(32'h600, BEQ, 1'b0, 3'd1);
    sb.push_back(f3_exc(3'd1, 5'd5, 1'b1, 5'd1, 31'h0, 32'h700, 32'h1234));
    trap(32'h700, 3'd1, 5'd5, 1'b1, 32'h1234);
    sb.push_back(f2(32'h800));
    retire(32'h800, NOP, 1'b0, 3'd1);
    idle(2);
    drain("drain_intr");

    // Backpressure: first held, second dropped
    @(negedge clk);
    tr.packet_ready_i = 1'b0;
    retire(32'h900, JALR, 1'b0, 3'd3);
    sb.push_back(f2(32'ha00));
    retire(32'ha00, JALR, 1'b0, 3'd3);
    retire(32'hb00, NOP, 1'b0, 3'd3);
    idle(1);
    sample();
    check("hold_valid", 128'(tr.packet_valid_o), 128'd1);
    check("hold_packet", tr.packet_o, f2(32'ha00).dat);
    check("overflow_set", 128'(overflow), 128'd1);
    sample();
    check("hold_packet2", tr.packet_o, f2(32'ha00).dat);
    @(negedge clk);
    tr.packet_ready_i = 1'b1;
    idle(2);
    drain("drain_bp");
    check("overflow_sticky", 128'(overflow), 128'd1);

    // Tracing off: nothing produced, re-enable gives sync
    retire(32'he00, BEQ, 1'b0, 3'd3);
    @(negedge clk);
    trace_enable = 1'b0;
    retire(32'he04, JALR, 1'b0, 3'd3);
    retire(32'he08, NOP, 1'b0, 3'd3);
    idle(1);
    sample();
    check("off_valid", 128'(tr.packet_valid_o), 128'd0);
    @(negedge clk);
    trace_enable = 1'b1;
    sb.push_back(f3_sync(3'd1, 32'hc00));
    retire(32'hc00, NOP, 1'b0, 3'd1);

    // Back-to-back F2 packets at full rate
    retire(32'hd00, JALR, 1'b0, 3'd1);
    sb.push_back(f2(32'hd10));
    retire(32'hd10, JALR, 1'b0, 3'd1);
    sb.push_back(f2(32'hd20));
    retire(32'hd20, JALR, 1'b0, 3'd1);
    sb.push_back(f2(32'hd30));
    retire(32'hd30, NOP, 1'b0, 3'd1);
    idle(2);
    drain("drain_b2b");

    // Reset with a packet held drops it and clears overflow
    @(negedge clk);
    tr.packet_ready_i = 1'b0;
    retire(32'hf00, JALR, 1'b0, 3'd3);
    retire(32'hf10, NOP, 1'b0, 3'd3);
    idle(1);
    sample();
    check("pre_rst_valid", 128'(tr.packet_valid_o), 128'd1);
    @(negedge clk);
    rst = 1'b1;
    sample();
    check("mid_rst_valid", 128'(tr.packet_valid_o), 128'd0);
    check("mid_rst_overflow", 128'(overflow), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    tr.packet_ready_i = 1'b1;
    sb.push_back(f3_sync(3'd0, 32'hf20));
    retire(32'hf20, NOP, 1'b0, 3'd0);
    idle(2);
    drain("drain_post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_debugger.md
# trace_debugger

Instruction-trace encoder sitting beside the core's retirement port. It watches each retired or excepting instruction and tracks conditional-branch outcomes. It emits compressed trace packets (sync, branch map, address, exception) on a valid/ready output for the trace sink.

## Interface
- PKT_W, 128: packet data width; must be ≥ 113.
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- test_mode_i  in  1  DFT only; no functional effect.
- trace_enable_i  in  1  tracing on.
- ivalid_i  in  1  instruction retires this cycle.
- iexception_i  in  1  instruction traps or is interrupted this cycle; qualified by ivalid_i.
- interrupt_i  in  1  the trap is an interrupt.
- cause_i  in  5  trap cause.
- tval_i  in  32  trap value.
- priv_i  in  3  privilege level.
- iaddr_i  in  32  instruction address.
- instr_i  in  32  instruction word.
- compressed_i  in  1  instruction is 16-bit.
- packet_valid_o  out  1  packet available.
- packet_ready_i  in  1  sink accepts the packet.
- packet_o  out  PKT_W  packet; unused MSBs are 0.
- packet_len_o  out  7  number of valid bits in packet_o.
- overflow_o  out  1  sticky: a packet was dropped.

## Operation
A retirement event is a cycle with ivalid_i=1 and trace_enable_i=1.

Instruction classification:
- Conditional branch: opcode 1100011, or compressed c.beqz/c.bnez (op=01, funct3=110/111).
- Uninferable jump: opcode 1100111 (jalr), or c.jr/c.jalr.

Branch resolution:
- A branch is resolved at the next retirement event.
- It is taken if the next iaddr_i ≠ branch iaddr + (compressed ? 2 : 4).
- The result is shifted into the branch map at bit [count]; 1 means not taken.
- The count is saturated at 31.

Packet selection, one per event, in priority order:
1. First event after reset or after a 0→1 transition of trace_enable_i: F3 sync.
   - Layout: [1:0]=11, [3:2]=00, [6:4]=priv, [38:7]=iaddr; len 39.
2. iexception_i: F3 exception.
   - Layout: [1:0]=11, [3:2]=01, [6:4]=priv, [11:7]=cause, [12]=interrupt, [17:13]=count, [48:18]=map, [80:49]=iaddr, [112:81]=tval; len 113.
   - Clears the branch map and count.
   - Marks the next event as a discontinuity.
3. Discontinuity: event following an uninferable jump or exception.
   - count>0: F1 with address: [1:0]=01, [6:2]=count, [37:7]=map, [69:38]=iaddr; len 70.
   - count=0: F2: [1:0]=10, [33:2]=iaddr; len 34.
4. Branch map full (count reaches 31 and no discontinuity): F1 without address, [6:2]=00000; len 38.
   - If the map fills on a discontinuity event, F1 count=31 with address is sent instead.

Clearing rules:
- Every F1/F2/F3 emission clears the map and count.
- A branch resolved on the same event is included before clearing.

trace_enable_i=0 discards all tracking state; no packets are produced while it is low.

Output handshake:
- Single-entry output register.
- A packet is held stable while packet_valid_o && !packet_ready_i.
- A new packet arriving while the register is full and not being accepted is dropped, and overflow_o is set.
- overflow_o clears only on reset.
- If ready is high in the same cycle the register frees, the new packet loads without loss.

## Timing
- Packet appears on packet_o/packet_valid_o one cycle after the triggering event (registered).
- Throughput: one packet per cycle when packet_ready_i is held high.
- Reset value of all outputs: 0. Internal state on reset: sync pending, count 0, no pending branch, no discontinuity flag.
- Reset asserted mid-packet drops the packet; the next event after reset produces F3 sync.

## Structure
- Shared package holds:
  - format codes (F1=01, F2=10, F3=11) and F3 subformats;
  - opcode/funct constants;
  - field offsets and lengths;
  - the packet struct typedef.
- One natural sub-module, trdb_branch_map: branch shift register, count, full flag, and flush.
- Top level contains the classifier, packet assembler and output register.

## Test plan
- Reset, enable, retire iaddr=0x80 priv=3 → F3 sync, len 39, packet_o[38:7]=0x80, [6:4]=3.
- After sync, beq at 0x100 then next at 0x104 → no packet; then a jalr at 0x108, target 0x200 → F1, count=1, map bit0=1, address 0x200, len 70.
- 31 consecutive taken branches → F1 count field 0, map all 0, len 38, emitted on the event resolving the 31st branch.
- Exception at 0x300, cause=2, tval=0xdead, with no pending branches → F3 sub 01, len 113. Next retire at 0x1000 → F2 address 0x1000.
- Hold packet_ready_i=0 and trigger two packets → first held stable, second dropped, overflow_o=1 until rst_i.
- Deassert then reassert trace_enable_i → no packets while low; next event produces F3 sync.
